// File: rtl/divider_pkg.sv
// Shared opcodes, FSM encoding and result fix-up helper for the RV64M divider.
package divider_pkg;

    localparam int XLEN = 64;

    localparam logic [7:0] INST_DIV   = 8'h50;
    localparam logic [7:0] INST_DIVU  = 8'h51;
    localparam logic [7:0] INST_REM   = 8'h52;
    localparam logic [7:0] INST_REMU  = 8'h53;
    localparam logic [7:0] INST_DIVW  = 8'h54;
    localparam logic [7:0] INST_DIVUW = 8'h55;
    localparam logic [7:0] INST_REMW  = 8'h56;
    localparam logic [7:0] INST_REMUW = 8'h57;

    localparam logic            RST_ENA   = 1'b1;
    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic            is_signed;
        logic            is_w;
        logic            is_rem;
        logic            neg_q;
        logic            neg_r;
        logic            dz;
        logic            ovf;
        logic [XLEN-1:0] ext_a;
    } op_info_t;

    // Applies sign fixes, RISC-V special results and W-form sign extension.
    function automatic logic [XLEN-1:0] fix_result(input logic [XLEN-1:0] q_mag,
                                                   input logic [XLEN-1:0] r_mag,
                                                   input op_info_t        info);
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        logic [XLEN-1:0] res;
        q = info.neg_q ? -q_mag : q_mag;
        r = info.neg_r ? -r_mag : r_mag;
        if (info.dz) begin
            q = '1;
            r = info.ext_a;
        end else if (info.ovf) begin
            q = info.ext_a;
            r = '0;
        end
        res = info.is_rem ? r : q;
        if (info.is_w)
            res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

endpackage

// File: rtl/div_operand_prep.sv
// Combinational operand decode: W-form extension, signs, magnitudes and special-case flags.
module div_operand_prep
    import divider_pkg::*;
(
    input  logic [7:0]      i_opcode,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output op_info_t        o_info,
    output logic [XLEN-1:0] o_abs_a,
    output logic [XLEN-1:0] o_abs_b
);

    logic            w_signed;
    logic            w_w;
    logic            w_rem;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_min;

    // Unknown opcodes fall through as DIVU.
    always_comb begin
        w_signed = 1'b0;
        w_w      = 1'b0;
        w_rem    = 1'b0;
        case (i_opcode)
            INST_DIV:   w_signed = 1'b1;
            INST_REM:   begin w_signed = 1'b1; w_rem = 1'b1; end
            INST_REMU:  w_rem = 1'b1;
            INST_DIVW:  begin w_signed = 1'b1; w_w = 1'b1; end
            INST_DIVUW: w_w = 1'b1;
            INST_REMW:  begin w_signed = 1'b1; w_w = 1'b1; w_rem = 1'b1; end
            INST_REMUW: begin w_w = 1'b1; w_rem = 1'b1; end
            default:    ;
        endcase
    end

    assign w_a = !w_w     ? i_op1 :
                 w_signed ? {{32{i_op1[31]}}, i_op1[31:0]} : {32'b0, i_op1[31:0]};
    assign w_b = !w_w     ? i_op2 :
                 w_signed ? {{32{i_op2[31]}}, i_op2[31:0]} : {32'b0, i_op2[31:0]};

    assign w_sa  = w_signed & w_a[XLEN-1];
    assign w_sb  = w_signed & w_b[XLEN-1];
    assign w_min = w_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;

    assign o_abs_a = w_sa ? -w_a : w_a;
    assign o_abs_b = w_sb ? -w_b : w_b;

    assign o_info.is_signed = w_signed;
    assign o_info.is_w      = w_w;
    assign o_info.is_rem    = w_rem;
    assign o_info.neg_q     = w_sa ^ w_sb;
    assign o_info.neg_r     = w_sa;
    assign o_info.dz        = (w_b == '0);
    assign o_info.ovf       = w_signed & (w_a == w_min) & (w_b == '1);
    assign o_info.ext_a     = w_a;

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/REM (incl. W forms).
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero/overflow skip straight to DONE.
module divider
    import divider_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            div_ready,
    input  logic [7:0]      inst_opcode,
    input  logic [XLEN-1:0] div_op1,
    input  logic [XLEN-1:0] div_op2,
    output logic [XLEN-1:0] div_result,
    output logic            div_finish,
    output logic            div_busy
);

    div_state_e      r_state;
    div_state_e      w_next_state;
    logic [5:0]      r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_divisor;
    op_info_t        r_info;
    logic [XLEN-1:0] r_result;

    op_info_t        w_info;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_fast;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_step_rem;
    logic [XLEN-1:0] w_step_quot;

    div_operand_prep u_prep (
        .i_opcode (inst_opcode),
        .i_op1    (div_op1),
        .i_op2    (div_op2),
        .o_info   (w_info),
        .o_abs_a  (w_abs_a),
        .o_abs_b  (w_abs_b)
    );

`ifdef DIV_FAST_SPECIAL_EN
    assign w_fast = w_info.dz | w_info.ovf;
`else
    assign w_fast = 1'b0;
`endif

    // 65-bit trial subtract: bit 64 is the borrow, since the shifted remainder is < 2*divisor.
    assign w_shift     = {r_rem, r_quot[XLEN-1]};
    assign w_diff      = w_shift - {1'b0, r_divisor};
    assign w_ge        = ~w_diff[XLEN];
    assign w_step_rem  = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_step_quot = {r_quot[XLEN-2:0], w_ge};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (div_ready) w_next_state = w_fast ? S_DONE : S_CALC;
            S_CALC:  if (!div_ready) w_next_state = S_IDLE;
                     else if (r_cnt == 6'd0) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_info    <= '0;
            r_result  <= ZERO_WORD;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: if (div_ready) begin
                    r_info    <= w_info;
                    r_divisor <= w_abs_b;
                    r_rem     <= '0;
                    // W ops iterate 32 times, so the dividend starts in the upper half.
                    r_quot    <= w_info.is_w ? {w_abs_a[31:0], 32'b0} : w_abs_a;
                    r_cnt     <= w_info.is_w ? 6'd31 : 6'd63;
                    if (w_fast)
                        r_result <= fix_result('0, '0, w_info);
                end
                S_CALC: if (div_ready) begin
                    r_rem  <= w_step_rem;
                    r_quot <= w_step_quot;
                    r_cnt  <= r_cnt - 6'd1;
                    if (r_cnt == 6'd0)
                        r_result <= fix_result(w_step_quot, w_step_rem, r_info);
                end
                default: ;
            endcase
        end
    end

    assign div_result = r_result;
    assign div_finish = (r_state == S_DONE);
    assign div_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the RV64M divider: results, latency, reset and abort.
module tb_divider;
    import divider_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_ready = 1'b0;
    logic [7:0]  inst_opcode = '0;
    logic [63:0] div_op1 = '0;
    logic [63:0] div_op2 = '0;
    logic [63:0] div_result;
    logic        div_finish;
    logic        div_busy;

    int n_vec = 0;
    int n_err = 0;

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    divider dut (
        .clk         (clk),
        .rst         (rst),
        .div_ready   (div_ready),
        .inst_opcode (inst_opcode),
        .div_op1     (div_op1),
        .div_op2     (div_op2),
        .div_result  (div_result),
        .div_finish  (div_finish),
        .div_busy    (div_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          w;
        bit          special;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat);
        @(negedge clk);
        inst_opcode = op;
        div_op1     = a;
        div_op2     = b;
        div_ready   = 1'b1;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (div_finish) break;
        end
        res = div_result;
        @(posedge clk);
        #1 div_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] prev;
        int          lat;
        int          exp_lat;
        bit          seen;

        tv.push_back('{INST_DIV,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 0, 0});
        tv.push_back('{INST_REM,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0});
        tv.push_back('{INST_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0});
        tv.push_back('{INST_REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 0, 0});
        tv.push_back('{INST_DIV,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1});
        tv.push_back('{INST_REMU,  64'd5, 64'd0, 64'd5, 0, 1});
        tv.push_back('{INST_DIVW,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1});
        tv.push_back('{INST_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1});
        tv.push_back('{INST_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1});
        tv.push_back('{INST_DIVW,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1});
        tv.push_back('{INST_DIVUW, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 1, 0});
        tv.push_back('{INST_REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0});
        tv.push_back('{INST_DIVW,  64'h1234_5678_0000_0064, 64'hABCD_0000_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 1, 0});
        tv.push_back('{INST_REMUW, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 1, 0});
        tv.push_back('{INST_REMUW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0});
        tv.push_back('{INST_DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 0, 0});
        tv.push_back('{INST_REM,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0});
        tv.push_back('{INST_REMW,  64'd5, 64'hFFFF_FFFF_0000_0000, 64'd5, 1, 1});
        tv.push_back('{8'h00,      64'd100, 64'd7, 64'd14, 0, 0});

        // Reset held with div_ready high: reset must win.
        div_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",   {63'b0, div_busy},   64'd0);
        chk("reset_finish", {63'b0, div_finish}, 64'd0);
        chk("reset_result", div_result,          64'd0);
        rst = 1'b0;
        div_ready = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            run_op(tv[i].op, tv[i].a, tv[i].b, res, lat);
            exp_lat = (tv[i].special && FAST) ? 1 : (tv[i].w ? 33 : 65);
            chk($sformatf("vec%0d_result", i), res, tv[i].exp);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), {63'b0, div_finish}, 64'd0);
            chk($sformatf("vec%0d_hold", i), div_result, tv[i].exp);
        end
        prev = div_result;

        // Abort: drop div_ready mid-CALC.
        @(negedge clk);
        inst_opcode = INST_DIVU; div_op1 = 64'd1000; div_op2 = 64'd10; div_ready = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_mid", {63'b0, div_busy}, 64'd1);
        div_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_idle",   {63'b0, div_busy}, 64'd0);
        chk("abort_result", div_result, prev);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (div_finish) seen = 1'b1;
        end
        chk("abort_no_finish", {63'b0, seen}, 64'd0);
        run_op(INST_DIVU, 64'd1000, 64'd10, res, lat);
        chk("restart_result",  res, 64'd100);
        chk("restart_latency", 64'(lat), 64'd65);

        // Reset in CALC cycle 20.
        @(negedge clk);
        inst_opcode = INST_DIV; div_op1 = 64'd100; div_op2 = 64'hFFFF_FFFF_FFFF_FFF9; div_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        div_ready = 1'b0;
        @(negedge clk);
        chk("rst_calc_busy",   {63'b0, div_busy},   64'd0);
        chk("rst_calc_finish", {63'b0, div_finish}, 64'd0);
        chk("rst_calc_result", div_result,          64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (div_finish) seen = 1'b1;
        end
        chk("rst_calc_no_finish", {63'b0, seen}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
